vrc_serial_scheduler: RTL

Serialises VRC register writes from the two Ethernet command channels onto the single shared 3-wire serial bus feeding both VRC chips. Sits directly after the command decoder: it takes the per-channel VRC address/data/write-enable strobes, buffers each channel in a small FIFO, arbitrates round-robin between them and shifts out one 16-bit frame at a time with a per-chip chip-select.

---
 rtl/vrc_pkg.sv | 17 +
 rtl/vrc_cmd_fifo.sv | 62 ++++++
 rtl/vrc_serial_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vrc_pkg.sv
// Shared types and constants for the VRC serial scheduler.
// Used by vrc_cmd_fifo and vrc_serial_scheduler.
package vrc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } vrc_state_e;

    localparam int VRC_FRAME_W     = 16;
    localparam int VRC_SHIFT_TICKS = 32;
    localparam int VRC_GAP_TICKS   = 2;

endpackage

// File: rtl/vrc_cmd_fifo.sv
// Per-channel command FIFO holding {addr,data} frames.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module vrc_cmd_fifo
    import vrc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [VRC_FRAME_W-1:0]   wdata_i,
    input  logic                     pop_i,
    output logic [VRC_FRAME_W-1:0]   rdata_o,
    output logic                     accept_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [VRC_FRAME_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_q, wr_d;
    logic [AW-1:0]          rd_q, rd_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   do_pop;

    assign full_o   = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign count_o  = cnt_q;
    assign rdata_o  = mem_q[rd_q];
    assign accept_o = push_i & (~full_o | pop_i);
    assign do_pop   = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (accept_o) wr_d = wr_q + 1'b1;
        if (do_pop)   rd_d = rd_q + 1'b1;
        if (accept_o && !do_pop) cnt_d = cnt_q + 1'b1;
        if (!accept_o && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (accept_o) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/vrc_serial_scheduler.sv
// Round-robin serialiser of two VRC command channels onto one 3-wire bus.
// Optional VRC_WRITE_ACK_EN adds per-channel o_done_n pulses at frame end.
module vrc_serial_scheduler
    import vrc_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_vrc_addr_0,
    input  logic [7:0] i_vrc_addr_1,
    input  logic [7:0] i_vrc_data_0,
    input  logic [7:0] i_vrc_data_1,
    input  logic       i_vrc_wren_0,
    input  logic       i_vrc_wren_1,
    input  logic       i_ovf_clr,
    output logic       o_sclk,
    output logic       o_sdata,
    output logic [1:0] o_cs_n,
    output logic       o_busy,
    output logic       o_ovf_0,
    output logic       o_ovf_1
`ifdef VRC_WRITE_ACK_EN
    ,
    output logic       o_done_0,
    output logic       o_done_1
`endif
);

    localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    vrc_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [5:0]             ti_q;
    logic [VRC_FRAME_W-1:0] sr_q;
    logic                   grant_q;
    logic                   last_q;
    logic                   busy_q, busy_d;
    logic                   ovf0_q, ovf1_q;

    logic [VRC_FRAME_W-1:0] rdata0, rdata1;
    logic [FCW-1:0]         fcnt0, fcnt1;
    logic [1:0]             full, empty, acc, pop;
    logic                   tick_end, start, any, arb_gnt, cs_act;
    logic                   ne0_next, ne1_next;

    vrc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (i_vrc_wren_0),
        .wdata_i  ({i_vrc_addr_0, i_vrc_data_0}),
        .pop_i    (pop[0]),
        .rdata_o  (rdata0),
        .accept_o (acc[0]),
        .full_o   (full[0]),
        .empty_o  (empty[0]),
        .count_o  (fcnt0)
    );

    vrc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (i_vrc_wren_1),
        .wdata_i  ({i_vrc_addr_1, i_vrc_data_1}),
        .pop_i    (pop[1]),
        .rdata_o  (rdata1),
        .accept_o (acc[1]),
        .full_o   (full[1]),
        .empty_o  (empty[1]),
        .count_o  (fcnt1)
    );

    assign tick_end = (cnt_q == CW'(CLK_DIV - 1));
    assign any      = ~empty[0] | ~empty[1];
    // On a tie serve the channel that was not served last.
    assign arb_gnt  = (!empty[0] && !empty[1]) ? ~last_q : empty[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // GAP hands straight to SETUP when work is pending, so the
    // frame period stays at 36 ticks.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE:  if (any) start = 1'b1;
            SETUP: if (tick_end) state_d = SHIFT;
            SHIFT: if (tick_end && ti_q == 6'(VRC_SHIFT_TICKS - 1))
                       state_d = HOLD;
            HOLD:  if (tick_end) state_d = GAP;
            GAP:   if (tick_end && ti_q == 6'(VRC_GAP_TICKS - 1)) begin
                       if (any) start   = 1'b1;
                       else     state_d = IDLE;
                   end
            default: state_d = IDLE;
        endcase
        if (start) state_d = SETUP;
    end

    always_comb begin
        pop = 2'b00;
        if (start) pop[arb_gnt] = 1'b1;
    end

    assign cs_act = (state_q == SETUP) | (state_q == SHIFT)
                  | (state_q == HOLD);

    always_comb begin
        o_cs_n  = 2'b11;
        o_sclk  = 1'b0;
        o_sdata = 1'b0;
        if (cs_act) begin
            o_cs_n  = grant_q ? 2'b01 : 2'b10;
            o_sdata = sr_q[VRC_FRAME_W-1];
        end
        if (state_q == SHIFT) o_sclk = ~ti_q[0];
    end

`ifdef VRC_WRITE_ACK_EN
    logic gap_first;
    assign gap_first = (state_q == GAP) && (ti_q == '0) && (cnt_q == '0);
    assign o_done_0  = gap_first & ~grant_q;
    assign o_done_1  = gap_first &  grant_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ti_q  <= '0;
        end else if (start || state_q == IDLE) begin
            cnt_q <= '0;
            ti_q  <= '0;
        end else begin
            cnt_q <= tick_end ? '0 : cnt_q + 1'b1;
            if (tick_end)
                ti_q <= (state_d != state_q) ? '0 : ti_q + 1'b1;
        end
    end

    // Shift on the falling sclk edge so data is stable at each rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else if (start) begin
            sr_q    <= arb_gnt ? rdata1 : rdata0;
            grant_q <= arb_gnt;
            last_q  <= arb_gnt;
        end else if (state_q == SHIFT && tick_end && !ti_q[0]) begin
            sr_q <= {sr_q[VRC_FRAME_W-2:0], 1'b0};
        end
    end

    assign ne0_next = acc[0] | (~empty[0] & (~pop[0] | fcnt0 != FCW'(1)));
    assign ne1_next = acc[1] | (~empty[1] & (~pop[1] | fcnt1 != FCW'(1)));
    assign busy_d   = (state_d != IDLE) | ne0_next | ne1_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            ovf0_q <= 1'b0;
            ovf1_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (i_vrc_wren_0 && !acc[0]) ovf0_q <= 1'b1;
            else if (i_ovf_clr)          ovf0_q <= 1'b0;
            if (i_vrc_wren_1 && !acc[1]) ovf1_q <= 1'b1;
            else if (i_ovf_clr)          ovf1_q <= 1'b0;
        end
    end

    assign o_busy  = busy_q;
    assign o_ovf_0 = ovf0_q;
    assign o_ovf_1 = ovf1_q;

endmodule
